futurefpga_slice_kn: RTL and testbench

Parametrised logic slice. It holds N LUT/FF elements, each with a K-input LUT. The elements are linked by a ripple carry chain, and each flip-flop has an optional clock enable and a configurable init value. Configuration is loaded through a serial scan chain (CFG_SI/CFG_SO) instead of a parallel bus, so slices can be daisy-chained across the fabric model. The slice sits in the arch_blocks tile model and is instantiated per CLB.

---
 rtl/futurefpga_slice_kn_if.sv | 25 ++
 rtl/futurefpga_slice_kn.sv | 119 +++++++++++
 tb/tb_futurefpga_slice_kn.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/futurefpga_slice_kn_if.sv
// Bus bundle for one logic slice: element inputs, carry, outputs and the
// serial configuration scan port. Suffixes are from the slice's point of view.
interface futurefpga_slice_kn_if #(
    parameter int K = 4,
    parameter int N = 2
);
    logic [N*K-1:0] in_i;
    logic           ce_i;
    logic           cin_i;
    logic           cfg_en_i;
    logic           cfg_si_i;
    logic           cout_o;
    logic [N-1:0]   o_o;
    logic           cfg_so_o;

    modport master (
        output in_i, ce_i, cin_i, cfg_en_i, cfg_si_i,
        input  cout_o, o_o, cfg_so_o
    );

    modport slave (
        input  in_i, ce_i, cin_i, cfg_en_i, cfg_si_i,
        output cout_o, o_o, cfg_so_o
    );
endinterface

// File: rtl/futurefpga_slice_kn.sv
// Logic slice: N K-input LUT/FF elements on a ripple carry chain, configured
// through a daisy-chainable serial scan register.
// Element field layout (low to high): INIT[2**K-1:0], FF_USED, FF_ISEL,
// CARRY_EN, CE_USED, FF_INIT. Top two config bits: CIN_SEL, CIN_CONST.
module futurefpga_slice_kn #(
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    futurefpga_slice_kn_if.slave bus
);
    localparam int LUTW      = 2 ** K;
    localparam int CW        = LUTW + 5;
    localparam int CFGW      = N * CW + 2;
    localparam int P_FF_USED = LUTW;
    localparam int P_FF_ISEL = LUTW + 1;
    localparam int P_CARRY   = LUTW + 2;
    localparam int P_CE_USED = LUTW + 3;
    localparam int P_FF_INIT = LUTW + 4;

    // Config is a power-up value only; reset deliberately leaves it alone.
    logic [CFGW-1:0] cfg_q = '0;
    logic [CFGW-1:0] cfg_d;
    logic [N-1:0]    ff_q = '0;
    logic [N-1:0]    ff_d;

    logic            gate;
    logic [N:0]      carry;
    logic [N-1:0]    lut_v;
    logic [N-1:0]    comb_v;
    logic [N-1:0]    gated_v;
    logic [N-1:0]    din_v;
    logic [N-1:0]    o_v;
    logic [N-1:0]    init_d;

    // Binary mux tree, MSB select resolved first; the ?: keeps agreeing
    // table entries defined when a select input is X.
    function automatic logic lut_mux(input logic [LUTW-1:0] tbl,
                                     input logic [K-1:0]    sel);
        logic [LUTW-1:0] t;
        t = tbl;
        for (int lvl = K - 1; lvl >= 0; lvl--) begin
            for (int j = 0; j < (1 << lvl); j++) begin
                t[j] = sel[lvl] ? t[j + (1 << lvl)] : t[j];
            end
        end
        return t[0];
    endfunction

    assign gate = rst_i | bus.cfg_en_i;

    // Scan chain next value: shift toward the MSB while enabled.
    always_comb begin
        cfg_d = cfg_q;
        if (bus.cfg_en_i) begin
            cfg_d = {cfg_q[CFGW-2:0], bus.cfg_si_i};
        end
    end

    // Scan register update.
    always_ff @(posedge clk_i) begin
        cfg_q <= cfg_d;
    end

    // LUTs, combinational ripple carry, output gating and FF data selection.
    always_comb begin
        carry    = '0;
        lut_v    = '0;
        comb_v   = '0;
        gated_v  = '0;
        din_v    = '0;
        o_v      = '0;
        carry[0] = cfg_q[CFGW-2] ? bus.cin_i : cfg_q[CFGW-1];
        for (int i = 0; i < N; i++) begin
            lut_v[i] = lut_mux(cfg_q[i*CW +: LUTW], bus.in_i[i*K +: K]);
            if (cfg_q[i*CW + P_CARRY]) begin
                comb_v[i]    = lut_v[i] ^ carry[i];
                carry[i + 1] = lut_v[i] ? carry[i] : bus.in_i[i*K];
            end else begin
                comb_v[i]    = lut_v[i];
                carry[i + 1] = carry[i];
            end
            gated_v[i] = gate ? 1'b0 : comb_v[i];
            din_v[i]   = cfg_q[i*CW + P_FF_ISEL] ? bus.in_i[i*K + K - 1] : gated_v[i];
            o_v[i]     = gate ? 1'b0 : (cfg_q[i*CW + P_FF_USED] ? ff_q[i] : gated_v[i]);
        end
    end

    // FF next state. FF_INIT is taken from the post-shift config so the last
    // scan edge already leaves the FFs at the newly loaded init value.
    always_comb begin
        ff_d   = ff_q;
        init_d = '0;
        for (int i = 0; i < N; i++) begin
            init_d[i] = cfg_d[i*CW + P_FF_INIT];
            if (bus.cfg_en_i) begin
                ff_d[i] = init_d[i];
            end else if (cfg_q[i*CW + P_CE_USED] && !bus.ce_i) begin
                ff_d[i] = ff_q[i];
            end else begin
                ff_d[i] = din_v[i];
            end
        end
    end

    // Element flip-flops; synchronous reset loads FF_INIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff_q <= init_d;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign bus.o_o      = o_v;
    assign bus.cout_o   = gate ? 1'b0 : carry[N];
    assign bus.cfg_so_o = cfg_q[CFGW-1];
endmodule

// File: tb/tb_futurefpga_slice_kn.sv
// Bench for the K=4, N=2 slice: a behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_futurefpga_slice_kn;
    localparam int K    = 4;
    localparam int N    = 2;
    localparam int CW   = 21;
    localparam int CFGW = 44;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    futurefpga_slice_kn_if #(.K(K), .N(N)) bus ();

    futurefpga_slice_kn #(.K(K), .N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    bit [CFGW-1:0] m_cfg  = '0;
    bit [N-1:0]    m_ff   = '0;
    bit            cmp_en = 1'b0;

    function automatic bit [20:0] el(bit ffi, bit ceu, bit cy, bit isel, bit ffu, bit [15:0] init);
        return {ffi, ceu, cy, isel, ffu, init};
    endfunction

    function automatic bit [CFGW-1:0] mk(bit cconst, bit csel, bit [20:0] e1, bit [20:0] e0);
        return {cconst, csel, e1, e0};
    endfunction

    function automatic bit [CFGW-1:0] f_cfg_next(bit [CFGW-1:0] c, bit en, bit si);
        return en ? {c[CFGW-2:0], si} : c;
    endfunction

    // Ungated element results: {carry out, comb values}.
    function automatic bit [N:0] f_comb(bit [CFGW-1:0] c, bit [N*K-1:0] in, bit cin);
        bit [N-1:0] y;
        bit         cy;
        bit [CW-1:0] f;
        bit [K-1:0]  idx;
        bit          lut;
        y  = '0;
        cy = c[CFGW-2] ? cin : c[CFGW-1];
        for (int i = 0; i < N; i++) begin
            f   = c[i*CW +: CW];
            idx = in[i*K +: K];
            lut = f[idx];
            if (f[18]) begin
                y[i] = lut ^ cy;
                if (!lut) cy = in[i*K];
            end else begin
                y[i] = lut;
            end
        end
        return {cy, y};
    endfunction

    function automatic bit [N-1:0] f_ff_next(bit [CFGW-1:0] c, bit [N-1:0] ff, bit [N*K-1:0] in,
                                             bit cin, bit r, bit en, bit si, bit ce);
        bit [CFGW-1:0] nc;
        bit [N:0]      cm;
        bit [N-1:0]    res;
        bit [CW-1:0]   f;
        nc  = f_cfg_next(c, en, si);
        cm  = f_comb(c, in, cin);
        res = ff;
        for (int i = 0; i < N; i++) begin
            f = c[i*CW +: CW];
            if (r || en)          res[i] = nc[i*CW + 20];
            else if (f[19] && !ce) res[i] = ff[i];
            else                  res[i] = f[17] ? in[i*K + K - 1] : cm[i];
        end
        return res;
    endfunction

    // Expected {COUT, O}.
    function automatic bit [N:0] f_exp(bit [CFGW-1:0] c, bit [N-1:0] ff, bit [N*K-1:0] in,
                                       bit cin, bit g);
        bit [N:0]    cm;
        bit [N-1:0]  o;
        bit [CW-1:0] f;
        if (g) return '0;
        cm = f_comb(c, in, cin);
        for (int i = 0; i < N; i++) begin
            f    = c[i*CW +: CW];
            o[i] = f[16] ? ff[i] : cm[i];
        end
        return {cm[N], o};
    endfunction

    always @(posedge clk) begin
        m_ff  <= f_ff_next(m_cfg, m_ff, bus.in_i, bus.cin_i, rst, bus.cfg_en_i, bus.cfg_si_i, bus.ce_i);
        m_cfg <= f_cfg_next(m_cfg, bus.cfg_en_i, bus.cfg_si_i);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_total++;
            if ({bus.cout_o, bus.o_o, bus.cfg_so_o} ===
                {f_exp(m_cfg, m_ff, bus.in_i, bus.cin_i, rst | bus.cfg_en_i), m_cfg[CFGW-1]}) begin
                n_pass++;
            end else begin
                $display("FAIL model_cmp t=%0t got {COUT,O,SO}=%b required {COUT,O}=%b SO=%b",
                         $time, {bus.cout_o, bus.o_o, bus.cfg_so_o},
                         f_exp(m_cfg, m_ff, bus.in_i, bus.cin_i, rst | bus.cfg_en_i), m_cfg[CFGW-1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input bit [N-1:0] eo, input bit ec);
        @(negedge clk);
        #1;
        n_total++;
        if (bus.o_o === eo && bus.cout_o === ec) begin
            n_pass++;
        end else begin
            $display("FAIL %s: O=%b COUT=%b, required O=%b COUT=%b", nm, bus.o_o, bus.cout_o, eo, ec);
        end
    endtask

    task automatic shift_cfg(input bit [CFGW-1:0] v, input bit chk, input bit tog);
        for (int b = CFGW - 1; b >= 0; b--) begin
            bus.cfg_en_i = 1'b1;
            bus.cfg_si_i = v[b];
            if (tog) bus.in_i = bus.in_i ^ 8'h88;
            if (chk) expect_out("shift_gated", 2'b00, 1'b0);
            tick();
        end
        bus.cfg_en_i = 1'b0;
        bus.cfg_si_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [CFGW-1:0] pat;
        bit [CFGW-1:0] got;
        pat = 44'hA5C3F096E1B;
        got = '0;
        bus.in_i     = '0;
        bus.ce_i     = 1'b0;
        bus.cin_i    = 1'b0;
        bus.cfg_en_i = 1'b0;
        bus.cfg_si_i = 1'b0;
        rst          = 1'b1;
        cmp_en       = 1'b1;

        tick();
        expect_out("reset_state", 2'b00, 1'b0);
        tick();

        // Scan integrity, with reset both during shifting and in a shift pause.
        rst = 1'b0;
        for (int b = CFGW - 1; b >= 0; b--) begin
            if (b == 30) begin
                rst          = 1'b1;
                bus.cfg_en_i = 1'b0;
                tick();
            end
            rst          = (b >= 20 && b <= 22);
            bus.cfg_en_i = 1'b1;
            bus.cfg_si_i = pat[b];
            tick();
        end
        rst          = 1'b0;
        bus.cfg_en_i = 1'b0;
        for (int j = 0; j < CFGW; j++) begin
            got[CFGW-1-j] = bus.cfg_so_o;
            bus.cfg_en_i  = 1'b1;
            bus.cfg_si_i  = 1'b0;
            tick();
        end
        bus.cfg_en_i = 1'b0;
        n_total++;
        if (got === pat) n_pass++;
        else $display("FAIL scan_integrity: got %h, required %h", got, pat);

        // AND4 LUT on element 0, combinational output.
        shift_cfg(mk(0, 0, el(0, 0, 0, 0, 0, 16'h0000), el(0, 0, 0, 0, 0, 16'h8000)), 1'b0, 1'b0);
        bus.in_i = 8'h0F;
        expect_out("and4_all_ones", 2'b01, 1'b0);
        bus.in_i = 8'h0E;
        expect_out("and4_0e", 2'b00, 1'b0);
        bus.in_i = 8'hF7;
        expect_out("and4_f7", 2'b00, 1'b0);
        rst      = 1'b1;
        bus.in_i = 8'h0F;
        expect_out("and4_rst_forces_0", 2'b00, 1'b0);
        tick();
        rst = 1'b0;

        // FF with clock enable and init value 1.
        shift_cfg(mk(0, 0, el(0, 0, 0, 0, 0, 16'h0000), el(1, 1, 0, 0, 1, 16'h0000)), 1'b0, 1'b0);
        rst      = 1'b1;
        bus.in_i = 8'h00;
        expect_out("ff_rst_gated", 2'b00, 1'b0);
        tick();
        rst      = 1'b0;
        bus.ce_i = 1'b0;
        expect_out("ff_init_after_rst", 2'b01, 1'b0);
        tick();
        expect_out("ff_ce_low_hold", 2'b01, 1'b0);
        bus.ce_i = 1'b1;
        expect_out("ff_ce_high_load", 2'b00, 1'b0);
        tick();

        // Two-bit adder on the carry chain, constant carry-in 0.
        shift_cfg(mk(0, 0, el(0, 0, 1, 0, 0, 16'h6666), el(0, 0, 1, 0, 0, 16'h6666)), 1'b0, 1'b0);
        bus.cin_i = 1'b0;
        bus.in_i  = 8'h13;
        expect_out("add_3_plus_1", 2'b00, 1'b1);
        bus.in_i  = 8'h03;
        expect_out("add_1_plus_1", 2'b10, 1'b0);
        tick();
        shift_cfg(mk(0, 1, el(0, 0, 1, 0, 0, 16'h6666), el(0, 0, 1, 0, 0, 16'h6666)), 1'b0, 1'b0);
        bus.cin_i = 1'b1;
        expect_out("add_1_plus_1_cin1", 2'b11, 1'b0);
        bus.in_i  = 8'h00;
        expect_out("add_0_plus_0_cin1", 2'b01, 1'b0);
        tick();
        bus.cin_i = 1'b0;

        // FF_ISEL bypass: registered copy of each element's top input bit.
        shift_cfg(mk(0, 0, el(0, 0, 0, 1, 1, 16'hFFFF), el(0, 0, 0, 1, 1, 16'hFFFF)), 1'b0, 1'b0);
        bus.in_i = 8'h08;
        tick();
        bus.in_i = 8'h80;
        expect_out("isel_same_cycle", 2'b01, 1'b0);
        expect_out("isel_next_cycle", 2'b10, 1'b0);
        tick();

        // Reconfiguration while outputs toggle.
        for (int c = 0; c < 4; c++) begin
            bus.in_i = bus.in_i ^ 8'h88;
            tick();
        end
        bus.ce_i = 1'b0;
        shift_cfg(mk(1, 0, el(0, 0, 0, 0, 0, 16'hFFFF), el(1, 1, 0, 0, 1, 16'h0000)), 1'b1, 1'b1);
        expect_out("reconfig_first_cycle", 2'b11, 1'b1);
        tick();
        expect_out("reconfig_hold", 2'b11, 1'b1);
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
